riscv_divider: RTL

Iterative radix-2 restoring divider for the RV64M divide/remainder instructions (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW).
- Sits in the execute stage, directly downstream of the register file.
- Consumes the rs1/rs2 operand values read from the register file after forwarding.
- Its result returns to the register-file write port via writeback.
- Asserts busy so the hazard unit can stall the pipeline while a division runs.

---
 rtl/riscv_divider.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_divider.sv
// riscv_divider: iterative radix-2 restoring divider for the RV64M
// DIV/DIVU/REM/REMU and their W variants.
//
// Ports:
//   i_riscv_div_clk      clock, rising edge
//   i_riscv_div_rst      asynchronous active-high reset
//   i_riscv_div_start    request, sampled only while idle
//   i_riscv_div_flush    synchronous abort (wins over start)
//   i_riscv_div_op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_riscv_div_wordop   1 = 32-bit W variant
//   i_riscv_div_rs1data  dividend
//   i_riscv_div_rs2data  divisor
//   o_riscv_div_result   quotient or remainder, held until next completion
//   o_riscv_div_valid    one-cycle completion pulse
//   o_riscv_div_busy     operation in progress (pipeline stall request)
module riscv_divider #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            i_riscv_div_clk,
  input  logic            i_riscv_div_rst,
  input  logic            i_riscv_div_start,
  input  logic            i_riscv_div_flush,
  input  logic [1:0]      i_riscv_div_op,
  input  logic            i_riscv_div_wordop,
  input  logic [XLEN-1:0] i_riscv_div_rs1data,
  input  logic [XLEN-1:0] i_riscv_div_rs2data,
  output logic [XLEN-1:0] o_riscv_div_result,
  output logic            o_riscv_div_valid,
  output logic            o_riscv_div_busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] ITER_FULL = CW'(XLEN - 1);
  localparam logic [CW-1:0] ITER_WORD = CW'(WLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t state, state_next;

  logic [1:0]      op_q;
  logic            wordop_q;
  logic            neg_q;      // negate quotient in SIGN
  logic            neg_r;      // negate remainder in SIGN
  logic [XLEN-1:0] quo;        // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] rem;        // partial remainder
  logic [XLEN-1:0] dvs;        // divisor magnitude
  logic [CW-1:0]   count;

  // ---------------- operand preparation (used at accept) ----------------
  logic            is_signed;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_neg;
  logic            a_neg, b_neg, div_zero, sgn_ovf, accept;

  always_comb begin
    is_signed = ~i_riscv_div_op[0];
    if (i_riscv_div_wordop) begin
      a_ext   = {{(XLEN-WLEN){is_signed & i_riscv_div_rs1data[WLEN-1]}},
                 i_riscv_div_rs1data[WLEN-1:0]};
      b_ext   = {{(XLEN-WLEN){is_signed & i_riscv_div_rs2data[WLEN-1]}},
                 i_riscv_div_rs2data[WLEN-1:0]};
      min_neg = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
    end else begin
      a_ext   = i_riscv_div_rs1data;
      b_ext   = i_riscv_div_rs2data;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    abs_a    = a_neg ? (~a_ext + 1'b1) : a_ext;
    abs_b    = b_neg ? (~b_ext + 1'b1) : b_ext;
    div_zero = (b_ext == '0);
    sgn_ovf  = is_signed && (a_ext == min_neg) && (b_ext == '1);
    accept   = (state == IDLE) && i_riscv_div_start && !i_riscv_div_flush;
  end

  // ---------------- restoring step ----------------
  logic [XLEN:0] trial;

  always_comb begin
    trial = {rem, quo[XLEN-1]} - {1'b0, dvs};
  end

  // ---------------- sign fix-up and result selection ----------------
  logic [XLEN-1:0] q_fix, r_fix, sel, res_next;

  always_comb begin
    q_fix = neg_q ? (~quo + 1'b1) : quo;
    r_fix = neg_r ? (~rem + 1'b1) : rem;
    sel   = op_q[1] ? r_fix : q_fix;
    if (wordop_q)
      res_next = {{(XLEN-WLEN){sel[WLEN-1]}}, sel[WLEN-1:0]};
    else
      res_next = sel;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_riscv_div_clk or posedge i_riscv_div_rst) begin
    if (i_riscv_div_rst) state <= IDLE;
    else                 state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (div_zero || sgn_ovf) ? SIGN : CALC;
      CALC: begin
        if (i_riscv_div_flush)   state_next = IDLE;
        else if (count == '0)    state_next = SIGN;
      end
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_riscv_div_busy = (state != IDLE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge i_riscv_div_clk or posedge i_riscv_div_rst) begin
    if (i_riscv_div_rst) begin
      op_q               <= '0;
      wordop_q           <= 1'b0;
      neg_q              <= 1'b0;
      neg_r              <= 1'b0;
      quo                <= '0;
      rem                <= '0;
      dvs                <= '0;
      count              <= '0;
      o_riscv_div_result <= '0;
      o_riscv_div_valid  <= 1'b0;
    end else begin
      o_riscv_div_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= i_riscv_div_op;
            wordop_q <= i_riscv_div_wordop;
            dvs      <= abs_b;
            count    <= i_riscv_div_wordop ? ITER_WORD : ITER_FULL;
            if (div_zero) begin
              // Special results are preloaded so SIGN passes them through.
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              quo   <= '1;
              rem   <= a_ext;
            end else if (sgn_ovf) begin
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              quo   <= a_ext;
              rem   <= '0;
            end else begin
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              // W ops start with the 32-bit dividend in the top half so that
              // 32 shifts leave the quotient in the low half.
              quo   <= i_riscv_div_wordop ? (abs_a << (XLEN - WLEN)) : abs_a;
              rem   <= '0;
            end
          end
        end
        CALC: begin
          if (!i_riscv_div_flush) begin
            if (!trial[XLEN]) begin
              rem <= trial[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= {rem[XLEN-2:0], quo[XLEN-1]};
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            count <= count - 1'b1;
          end
        end
        SIGN: begin
          if (!i_riscv_div_flush) begin
            o_riscv_div_result <= res_next;
            o_riscv_div_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
